// File: rtl/qam_pkg.sv
// Shared types, bits-per-symbol helper and Gray-to-PAM level tables for the
// streaming QAM mapper (qam_mapper_stream) and its PAM lookup (qam_pam_lut).
package qam_pkg;

    // Run-time modulation selector, encoded as on the mod_sel port.
    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_64QAM = 2'd3
    } mod_t;

    // Number of PAM levels on one axis; LVL_ZERO forces a 0 level (BPSK Q).
    typedef enum logic [1:0] {
        LVL_ZERO = 2'd0,
        LVL_2    = 2'd1,
        LVL_4    = 2'd2,
        LVL_8    = 2'd3
    } lvl_sel_t;

    // Odd-integer PAM level, -7..+7.
    typedef logic signed [3:0] level_t;

    // Gray code -> level, indexed by the Gray bits of one axis.
    localparam level_t LVL2_TBL [0:1] = '{-4'sd1, 4'sd1};
    localparam level_t LVL4_TBL [0:3] = '{-4'sd3, -4'sd1, 4'sd3, 4'sd1};
    localparam level_t LVL8_TBL [0:7] = '{-4'sd7, -4'sd5, -4'sd1, -4'sd3,
                                          4'sd7,  4'sd5,  4'sd1,  4'sd3};

    // Bits consumed per symbol for each modulation.
    function automatic logic [2:0] bps_of(input mod_t m);
        logic [2:0] b;
        case (m)
            MOD_BPSK:  b = 3'd1;
            MOD_QPSK:  b = 3'd2;
            MOD_16QAM: b = 3'd4;
            default:   b = 3'd6;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/qam_pam_lut.sv
// Combinational Gray-to-PAM lookup for one axis (I or Q): up to three Gray
// bits plus a level-count select give a signed odd-integer level.
module qam_pam_lut
    import qam_pkg::*;
(
    input  logic [2:0] gray,
    input  lvl_sel_t   sel,
    output level_t     level
);

    // Pick the table matching the constellation size on this axis.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred when a branch is added or missed.
        level = '0;
        case (sel)
            LVL_2:   level = LVL2_TBL[gray[0]];
            LVL_4:   level = LVL4_TBL[gray[1:0]];
            LVL_8:   level = LVL8_TBL[gray];
            default: level = '0;
        endcase
    end

endmodule

// File: rtl/qam_mapper_stream.sv
// Streaming BPSK/QPSK/16QAM/64QAM mapper. Packed input beats are appended
// LSB-first into a bit buffer; each symbol takes the low bps bits, maps them
// through Gray-coded PAM tables and drives a registered valid/ready output.
// Optional build macro QAM_SYM_CNT_EN adds a 32-bit handshake counter port
// sym_cnt.
module qam_mapper_stream
    import qam_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 16,
    parameter int AMP_STEP = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mod_sel,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  i_out,
    output logic [OUT_W-1:0]  q_out,
    output logic              idle
`ifdef QAM_SYM_CNT_EN
    ,
    output logic [31:0]       sym_cnt
`endif
);

    // Five spare bits beyond one beat so a beat can land while up to five
    // bits (less than one 64QAM symbol) are still waiting.
    localparam int BUF_W = DATA_W + 5;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic signed [OUT_W-1:0] AMP = OUT_W'(AMP_STEP);

    logic [BUF_W-1:0] bit_buf;
    logic [CNT_W-1:0] cnt;
    mod_t             mode_q;
    logic             flush_pend;

    logic [CNT_W-1:0] bps;
    logic             push;
    logic             out_free;
    logic             have_sym;
    logic             pad_sym;
    logic             load;
    logic [CNT_W-1:0] pop_n;
    logic [CNT_W-1:0] cnt_kept;
    logic [CNT_W-1:0] cnt_next;
    logic [BUF_W-1:0] buf_next;
    logic             pend_next;
    logic [5:0]       sym;

    logic [2:0]       i_gray;
    logic [2:0]       q_gray;
    lvl_sel_t         i_sel;
    lvl_sel_t         q_sel;
    level_t           i_lvl;
    level_t           q_lvl;
    logic signed [OUT_W-1:0] i_map;
    logic signed [OUT_W-1:0] q_map;

    assign bps      = CNT_W'(bps_of(mode_q));
    assign s_ready  = (cnt <= CNT_W'(BUF_W - DATA_W)) && !flush_pend;
    assign push     = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;
    assign idle     = (cnt == '0) && !m_valid && !flush_pend;

    // A full symbol is preferred; the zero-padded flush symbol only fires
    // once fewer than bps bits remain.
    assign have_sym = (cnt >= bps);
    assign pad_sym  = flush_pend && (cnt != '0) && (cnt < bps);
    assign load     = out_free && (have_sym || pad_sym);

    // Bits above cnt are always zero, so a padded symbol is just the low
    // bps bits of the buffer and popping cnt bits empties it.
    assign pop_n    = load ? (have_sym ? bps : cnt) : '0;
    assign cnt_kept = cnt - pop_n;
    assign cnt_next = cnt_kept + (push ? CNT_W'(DATA_W) : '0);
    assign buf_next = (bit_buf >> pop_n)
                    | (push ? (BUF_W'(s_data) << cnt_kept) : '0);

    // A flush with bits present stays pending until the buffer drains; any
    // full symbols still queued go out first, then the padded remainder.
    assign pend_next = (flush_pend || (flush && (cnt != '0))) && (cnt_next != '0);

    assign sym = bit_buf[5:0];

    // Split the symbol into per-axis Gray fields for the current mode.
    always_comb begin
        i_gray = '0;
        q_gray = '0;
        i_sel  = LVL_ZERO;
        q_sel  = LVL_ZERO;
        case (mode_q)
            MOD_BPSK: begin
                i_gray = {2'b00, sym[0]};
                i_sel  = LVL_2;
            end
            MOD_QPSK: begin
                i_gray = {2'b00, sym[0]};
                q_gray = {2'b00, sym[1]};
                i_sel  = LVL_2;
                q_sel  = LVL_2;
            end
            MOD_16QAM: begin
                i_gray = {1'b0, sym[1:0]};
                q_gray = {1'b0, sym[3:2]};
                i_sel  = LVL_4;
                q_sel  = LVL_4;
            end
            default: begin
                i_gray = sym[2:0];
                q_gray = sym[5:3];
                i_sel  = LVL_8;
                q_sel  = LVL_8;
            end
        endcase
    end

    qam_pam_lut u_lut_i (
        .gray  (i_gray),
        .sel   (i_sel),
        .level (i_lvl)
    );

    qam_pam_lut u_lut_q (
        .gray  (q_gray),
        .sel   (q_sel),
        .level (q_lvl)
    );

    assign i_map = {{(OUT_W-4){i_lvl[3]}}, i_lvl} * AMP;
    assign q_map = {{(OUT_W-4){q_lvl[3]}}, q_lvl} * AMP;

    // Bit buffer, fill count, flush state and mode capture at stream gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf    <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            mode_q     <= MOD_BPSK;
        end else begin
            // NOTE: non-blocking updates make every register see the values
            // from before this edge, independent of statement order.
            bit_buf    <= buf_next;
            cnt        <= cnt_next;
            flush_pend <= pend_next;
            if (idle) begin
                mode_q <= mod_t'(mod_sel);
            end
        end
    end

    // Output register: load a new symbol when free, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            i_out   <= '0;
            q_out   <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            i_out   <= i_map;
            q_out   <= q_map;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef QAM_SYM_CNT_EN
    // Count completed output handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
        end else if (m_valid && m_ready) begin
            sym_cnt <= sym_cnt + 32'd1;
        end
    end
`endif

endmodule
